mem_access_ctrl: RTL and testbench

Multi-cycle load/store initiator that sits between the core's execute/memory stage and the byte-addressable `memory` block. It accepts one access request at a time from the core over a valid/ready handshake and checks it for range, alignment and write-protection faults. Legal requests are sequenced onto the memory's `wr_en`/`address`/`in_val`/`mem_size`/`mem_sz_ex_sel` ports, and read data or a fault cause is returned to the core as a one-cycle response. It also keeps saturating load, store and fault counters for debug.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_req_checker.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: bus width, access
// size encodings, fault cause codes, FSM states and a saturating increment.
package mem_pkg;

  localparam int BUS_WIDTH = 32;

  // Access size encodings as seen on req_size / mem_size.
  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;

  // Fault cause codes reported on resp_cause.
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE    = 2'd2;
  localparam logic [1:0] CAUSE_IWRITE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Debug counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_req_checker.sv
// Combinational request classifier: out of range beats misalignment, which
// beats a store into the read-only instruction region.
module mem_req_checker
  import mem_pkg::*;
#(
  parameter int MEM_BYTES   = 256,
  parameter int INSTR_LIMIT = 64
) (
  input  logic [BUS_WIDTH-1:0] addr_i,
  input  logic [1:0]           size_i,
  input  logic                 wr_i,
  output logic                 fault_o,
  output logic [1:0]           cause_o
);

  localparam logic [BUS_WIDTH-1:0] RANGE_END = BUS_WIDTH'(MEM_BYTES);
  localparam logic [BUS_WIDTH-1:0] INSTR_END = BUS_WIDTH'(INSTR_LIMIT);

  logic misalign;

  // Classify the request with a fixed priority chain.
  always_comb begin
    misalign = ((size_i == WORD) && (addr_i[1:0] != 2'b00)) ||
               ((size_i == HALF_WORD) && addr_i[0]) ||
               (size_i == 2'b11);
    fault_o  = 1'b0;
    cause_o  = CAUSE_NONE;
    if (addr_i >= RANGE_END) begin
      fault_o = 1'b1;
      cause_o = CAUSE_RANGE;
    end else if (misalign) begin
      fault_o = 1'b1;
      cause_o = CAUSE_MISALIGN;
    end else if (wr_i && (addr_i < INSTR_END)) begin
      fault_o = 1'b1;
      cause_o = CAUSE_IWRITE;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store initiator: accepts one request at a time, rejects
// faulty ones without touching memory, sequences legal ones onto the memory
// ports and returns a one-cycle response. Keeps saturating debug counters.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_BYTES   = 256,
  parameter int INSTR_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_ex_sel,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_fault,
  output logic [1:0]           resp_cause,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_in_val,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex_sel,
  input  logic [BUS_WIDTH-1:0] mem_out_val,
  output logic [15:0]          stat_loads,
  output logic [15:0]          stat_stores,
  output logic [15:0]          stat_faults
);

  state_e               state_q, state_d;
  logic                 chk_fault;
  logic [1:0]           chk_cause;
  logic                 accept;
  logic                 req_wr_q;
  logic [BUS_WIDTH-1:0] mem_address_q, mem_in_val_q, resp_rdata_q;
  logic [1:0]           mem_size_q, resp_cause_q;
  logic                 mem_sz_ex_sel_q, resp_fault_q;
  logic [15:0]          stat_loads_q, stat_stores_q, stat_faults_q;

  mem_req_checker #(
    .MEM_BYTES  (MEM_BYTES),
    .INSTR_LIMIT(INSTR_LIMIT)
  ) u_checker (
    .addr_i (req_addr),
    .size_i (req_size),
    .wr_i   (req_wr),
    .fault_o(chk_fault),
    .cause_o(chk_cause)
  );

  assign accept = (state_q == ST_IDLE) && req_valid;

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/strobe outputs. The write strobe is gated by
  // rst so a store whose ACCESS cycle meets reset never commits.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = ~rst;
        if (req_valid) state_d = chk_fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_wr_en = req_wr_q & ~rst;
        state_d   = req_wr_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, memory port registers and response registers. Faulty
  // requests leave the memory ports untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_q        <= 1'b0;
      mem_address_q   <= '0;
      mem_in_val_q    <= '0;
      mem_size_q      <= '0;
      mem_sz_ex_sel_q <= 1'b0;
      resp_rdata_q    <= '0;
      resp_fault_q    <= 1'b0;
      resp_cause_q    <= CAUSE_NONE;
    end else if (accept) begin
      req_wr_q <= req_wr;
      if (chk_fault) begin
        resp_rdata_q <= '0;
        resp_fault_q <= 1'b1;
        resp_cause_q <= chk_cause;
      end else begin
        mem_address_q   <= req_addr;
        mem_in_val_q    <= req_wdata;
        mem_size_q      <= req_size;
        mem_sz_ex_sel_q <= req_ex_sel;
      end
    end else if ((state_q == ST_ACCESS) && req_wr_q) begin
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else if (state_q == ST_WAIT) begin
      resp_rdata_q <= mem_out_val;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end
  end

  // Debug counters advance once per completed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_faults_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (resp_fault_q)  stat_faults_q <= sat_inc(stat_faults_q);
      else if (req_wr_q) stat_stores_q <= sat_inc(stat_stores_q);
      else               stat_loads_q  <= sat_inc(stat_loads_q);
    end
  end

  assign mem_address   = mem_address_q;
  assign mem_in_val    = mem_in_val_q;
  assign mem_size      = mem_size_q;
  assign mem_sz_ex_sel = mem_sz_ex_sel_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_fault    = resp_fault_q;
  assign resp_cause    = resp_cause_q;
  assign stat_loads    = stat_loads_q;
  assign stat_stores   = stat_stores_q;
  assign stat_faults   = stat_faults_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a byte-addressable little-endian memory stands
// in for the memory block (ex_sel=1 sign-extends byte/half reads), and a
// reference model predicts responses, latencies, memory contents and counters.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_wr, req_ex_sel;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_in_val, mem_out_val;
  logic [1:0]  req_size, resp_cause, mem_size;
  logic        resp_valid, resp_fault, mem_wr_en, mem_sz_ex_sel;
  logic [15:0] stat_loads, stat_stores, stat_faults;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_BYTES(256), .INSTR_LIMIT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
    .req_ex_sel(req_ex_sel), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .resp_cause(resp_cause),
    .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_in_val(mem_in_val),
    .mem_size(mem_size), .mem_sz_ex_sel(mem_sz_ex_sel), .mem_out_val(mem_out_val),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
  );

  // ---------------- memory block stand-in ----------------
  logic [7:0] env_mem [256];
  logic [7:0] init_img [256];
  logic       load_en;
  logic [7:0] rd_a;
  logic [15:0] rd_h;

  always_comb begin
    mem_out_val = '0;
    rd_a = mem_address[7:0];
    rd_h = {env_mem[rd_a + 8'd1], env_mem[rd_a]};
    if (mem_address < 32'd256) begin
      case (mem_size)
        2'b00: mem_out_val = mem_sz_ex_sel ? {{24{env_mem[rd_a][7]}}, env_mem[rd_a]} : {24'h0, env_mem[rd_a]};
        2'b01: mem_out_val = mem_sz_ex_sel ? {{16{rd_h[15]}}, rd_h} : {16'h0, rd_h};
        default: mem_out_val = {env_mem[rd_a + 8'd3], env_mem[rd_a + 8'd2], rd_h};
      endcase
    end
  end

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_img[i];
    end else if (mem_wr_en && mem_address < 32'd256) begin
      env_mem[mem_address[7:0]] <= mem_in_val[7:0];
      if (mem_size != 2'b00) env_mem[mem_address[7:0] + 8'd1] <= mem_in_val[15:8];
      if (mem_size == 2'b10) begin
        env_mem[mem_address[7:0] + 8'd2] <= mem_in_val[23:16];
        env_mem[mem_address[7:0] + 8'd3] <= mem_in_val[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  int exp_loads, exp_stores, exp_faults;
  int n_cmp, n_fail;

  task automatic predict(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                         input bit ex, input logic [31:0] wdata, output bit f,
                         output logic [1:0] c, output logic [31:0] rd, output int lat);
    int nbytes;
    longint val;
    nbytes = 1 << size;
    f = 0; c = 0; rd = 0; val = 0;
    if (addr >= 256) c = 2;
    else if (size == 2'd3 || (addr % nbytes) != 0) c = 1;
    else if (wr && addr < 64) c = 3;
    if (c != 0) begin
      f = 1; lat = 1;
      if (exp_faults < 65535) exp_faults++;
    end else if (wr) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
      lat = 2;
      if (exp_stores < 65535) exp_stores++;
    end else begin
      for (int i = 0; i < nbytes; i++) val = val | (longint'(ref_mem[int'(addr) + i]) << (8 * i));
      if (ex && nbytes < 4 && val[8 * nbytes - 1]) val = val - (64'd1 << (8 * nbytes));
      rd = val[31:0];
      lat = 3;
      if (exp_loads < 65535) exp_loads++;
    end
  endtask

  // Drive one request and observe it: latency counted in sampled cycles
  // after the accepting edge, write strobes seen, and the response fields.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input bit ex, input logic [31:0] wdata, output int lat,
                        output logic [31:0] rd, output bit f, output logic [1:0] c,
                        output int wr_pulses, output logic [31:0] wr_addr);
    int w;
    lat = -1; rd = '0; f = 0; c = 0; wr_pulses = 0; wr_addr = '0; w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1; req_wr = wr; req_addr = addr; req_size = size; req_ex_sel = ex; req_wdata = wdata;
    @(negedge clk);
    req_valid = 0; req_wr = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_ex_sel = 1'($urandom); req_wdata = $urandom;
    for (int k = 1; k <= 6; k++) begin
      if (mem_wr_en) begin wr_pulses++; wr_addr = mem_address; end
      if (resp_valid) begin lat = k; rd = resp_rdata; f = resp_fault; c = resp_cause; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_one_cycle: resp_valid=%0b required 0", resp_valid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; load_en = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_size = 0; req_ex_sel = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 0; load_en = 0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
    n_cmp++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b required 0", mem_wr_en); end
    n_cmp++; if ({mem_address, resp_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_regs: addr=%h rdata=%h required 0", mem_address, resp_rdata); end
    n_cmp++; if ({stat_loads, stat_stores, stat_faults} !== 48'h0) begin n_fail++; $display("FAIL reset_counters: %h %h %h required 0", stat_loads, stat_stores, stat_faults); end
    $display("reset: counters=%0d/%0d/%0d ready=%0b", stat_loads, stat_stores, stat_faults, req_ready);
  endtask

  task automatic test_store_byte();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp;
    predict(1, 32'd65, 2'b00, 0, 32'h0000FFFF, ef, ec, erd, elat);
    do_req(1, 32'd65, 2'b00, 0, 32'h0000FFFF, lat, rd, f, c, wp, wa);
    $display("store_byte: addr=65 lat=%0d fault=%0b wr_pulses=%0d wr_addr=%0d stores=%0d", lat, f, wp, wa, stat_stores);
    n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL store_byte_latency: got %0d required %0d", lat, elat); end
    n_cmp++; if (f !== ef) begin n_fail++; $display("FAIL store_byte_fault: got %0b required %0b", f, ef); end
    n_cmp++; if (wp !== 1 || wa !== 32'd65) begin n_fail++; $display("FAIL store_byte_wr: pulses=%0d addr=%0d required 1/65", wp, wa); end
    n_cmp++; if (stat_stores !== 16'(exp_stores)) begin n_fail++; $display("FAIL store_byte_count: got %0d required %0d", stat_stores, exp_stores); end
  endtask

  task automatic test_word_load();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp;
    predict(0, 32'd8, 2'b10, 0, 32'h0, ef, ec, erd, elat);
    do_req(0, 32'd8, 2'b10, 0, 32'h0, lat, rd, f, c, wp, wa);
    $display("word_load: addr=8 lat=%0d rdata=%h fault=%0b loads=%0d", lat, rd, f, stat_loads);
    n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL word_load_latency: got %0d required %0d", lat, elat); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rd !== erd) begin n_fail++; $display("FAIL word_load_rdata: got %h required %h", rd, erd); end
    n_cmp++; if (f !== 1'b0 || wp !== 0) begin n_fail++; $display("FAIL word_load_fault: fault=%0b wr=%0d required 0/0", f, wp); end
    n_cmp++; if (stat_loads !== 16'(exp_loads)) begin n_fail++; $display("FAIL word_load_count: got %0d required %0d", stat_loads, exp_loads); end
  endtask

  task automatic test_iwrite();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa, addr_before; int lat, elat, wp;
    addr_before = mem_address;
    predict(1, 32'd4, 2'b10, 0, 32'h12345678, ef, ec, erd, elat);
    do_req(1, 32'd4, 2'b10, 0, 32'h12345678, lat, rd, f, c, wp, wa);
    $display("iwrite: addr=4 lat=%0d fault=%0b cause=%0d wr_pulses=%0d", lat, f, c, wp);
    n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL iwrite_latency: got %0d required %0d", lat, elat); end
    n_cmp++; if (f !== ef || c !== ec) begin n_fail++; $display("FAIL iwrite_cause: got %0b/%0d required %0b/%0d", f, c, ef, ec); end
    n_cmp++; if (wp !== 0 || mem_address !== addr_before) begin n_fail++; $display("FAIL iwrite_mem_touched: pulses=%0d addr=%h required 0/%h", wp, mem_address, addr_before); end
    predict(0, 32'd4, 2'b10, 0, 32'h0, ef, ec, erd, elat);
    do_req(0, 32'd4, 2'b10, 0, 32'h0, lat, rd, f, c, wp, wa);
    $display("iwrite_readback: addr=4 rdata=%h", rd);
    n_cmp++; if (rd !== erd || f !== 1'b0) begin n_fail++; $display("FAIL iwrite_readback: got %h required %h", rd, erd); end
  endtask

  task automatic test_priority();
    logic [31:0] t_addr [4] = '{32'd66, 32'd256, 32'd2, 32'd64};
    logic [1:0]  t_size [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    bit          t_wr   [4] = '{0, 0, 1, 0};
    logic [1:0]  t_cause[4] = '{2'd1, 2'd2, 2'd1, 2'd1};
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp;
    for (int i = 0; i < 4; i++) begin
      predict(t_wr[i], t_addr[i], t_size[i], 0, 32'hCAFE0000, ef, ec, erd, elat);
      do_req(t_wr[i], t_addr[i], t_size[i], 0, 32'hCAFE0000, lat, rd, f, c, wp, wa);
      $display("priority: wr=%0b addr=%0d size=%0d cause=%0d lat=%0d", t_wr[i], t_addr[i], t_size[i], c, lat);
      n_cmp++; if (c !== ec || c !== t_cause[i] || f !== 1'b1 || lat !== elat) begin n_fail++; $display("FAIL priority_%0d: cause=%0d lat=%0d required %0d/%0d", i, c, lat, t_cause[i], elat); end
    end
    n_cmp++; if (stat_faults !== 16'(exp_faults)) begin n_fail++; $display("FAIL priority_count: got %0d required %0d", stat_faults, exp_faults); end
  endtask

  task automatic test_mmio_store();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp;
    predict(1, 32'd128, 2'b00, 0, 32'h0000005A, ef, ec, erd, elat);
    do_req(1, 32'd128, 2'b00, 0, 32'h0000005A, lat, rd, f, c, wp, wa);
    $display("mmio_store: addr=128 lat=%0d fault=%0b wr_pulses=%0d", lat, f, wp);
    n_cmp++; if (lat !== elat || f !== ef || wp !== 1) begin n_fail++; $display("FAIL mmio_store: lat=%0d fault=%0b pulses=%0d required %0d/%0b/1", lat, f, wp, elat, ef); end
  endtask

  task automatic test_back_to_back();
    bit ef; logic [1:0] ec; logic [31:0] erd; int elat, n_rdy, n_rsp, n_wr, exp_acc;
    n_rdy = 0; n_rsp = 0; n_wr = 0;
    while (!req_ready) @(negedge clk);
    req_valid = 1; req_wr = 1; req_addr = 32'd128; req_size = 2'b00; req_ex_sel = 0; req_wdata = 32'h000000C3;
    for (int k = 0; k < 9; k++) begin
      if (req_ready) n_rdy++;
      if (resp_valid) n_rsp++;
      if (mem_wr_en) n_wr++;
      @(negedge clk);
    end
    req_valid = 0;
    predict(1, 32'd128, 2'b00, 0, 32'h000000C3, ef, ec, erd, elat);
    exp_acc = 9 / (elat + 1);
    for (int k = 1; k < exp_acc; k++) predict(1, 32'd128, 2'b00, 0, 32'h000000C3, ef, ec, erd, elat);
    @(negedge clk);
    $display("back_to_back: accepts=%0d responses=%0d writes=%0d stores=%0d", n_rdy, n_rsp, n_wr, stat_stores);
    n_cmp++; if (n_rdy !== exp_acc || n_rsp !== exp_acc || n_wr !== exp_acc) begin n_fail++; $display("FAIL back_to_back: %0d/%0d/%0d required %0d each", n_rdy, n_rsp, n_wr, exp_acc); end
    n_cmp++; if (stat_stores !== 16'(exp_stores)) begin n_fail++; $display("FAIL back_to_back_count: got %0d required %0d", stat_stores, exp_stores); end
  endtask

  task automatic test_random();
    bit f, ef, wr, ex; logic [1:0] c, ec, size; logic [31:0] rd, erd, wa, addr, wd; int lat, elat, wp, sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 32'd256 + $urandom_range(0, 40);
      else if (sel == 1) addr = $urandom | 32'h8000_0000;
      else if (sel < 4)  addr = $urandom_range(0, 63);
      else               addr = $urandom_range(64, 255);
      size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (size != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      wr = 1'($urandom); ex = 1'($urandom); wd = $urandom;
      predict(wr, addr, size, ex, wd, ef, ec, erd, elat);
      do_req(wr, addr, size, ex, wd, lat, rd, f, c, wp, wa);
      $display("random[%0d]: wr=%0b addr=%h size=%0d ex=%0b lat=%0d fault=%0b cause=%0d rdata=%h", n, wr, addr, size, ex, lat, f, c, rd);
      n_cmp++;
      if (lat !== elat || f !== ef || c !== ec || (!ef && !wr && rd !== erd) || wp !== ((!ef && wr) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL random_%0d: lat=%0d f=%0b c=%0d rd=%h wr=%0d required %0d/%0b/%0d/%h", n, lat, f, c, rd, wp, elat, ef, ec, erd);
      end
    end
    n_cmp++;
    if (stat_loads !== 16'(exp_loads) || stat_stores !== 16'(exp_stores) || stat_faults !== 16'(exp_faults)) begin
      n_fail++; $display("FAIL random_counters: %0d/%0d/%0d required %0d/%0d/%0d", stat_loads, stat_stores, stat_faults, exp_loads, exp_stores, exp_faults);
    end
  endtask

  task automatic test_reset_wait();
    int n_rsp;
    n_rsp = 0;
    while (!req_ready) @(negedge clk);
    req_valid = 1; req_wr = 0; req_addr = 32'd8; req_size = 2'b10; req_ex_sel = 0; req_wdata = 0;
    @(negedge clk); req_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; #1;
    exp_loads = 0; exp_stores = 0; exp_faults = 0;
    for (int k = 0; k < 4; k++) begin if (resp_valid) n_rsp++; @(negedge clk); end
    $display("reset_wait: responses=%0d ready=%0b counters=%0d/%0d/%0d", n_rsp, req_ready, stat_loads, stat_stores, stat_faults);
    n_cmp++; if (n_rsp !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wait_drop: responses=%0d ready=%0b required 0/1", n_rsp, req_ready); end
    n_cmp++; if ({stat_loads, stat_stores, stat_faults} !== 48'h0) begin n_fail++; $display("FAIL reset_wait_counters: %0d/%0d/%0d required 0", stat_loads, stat_stores, stat_faults); end
  endtask

  task automatic test_reset_store();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp; logic wr_seen;
    while (!req_ready) @(negedge clk);
    req_valid = 1; req_wr = 1; req_addr = 32'd100; req_size = 2'b00; req_ex_sel = 0; req_wdata = {24'h0, ~ref_mem[100]};
    @(negedge clk); req_valid = 0; rst = 1; #1;
    wr_seen = mem_wr_en;
    @(negedge clk); rst = 0;
    exp_loads = 0; exp_stores = 0; exp_faults = 0;
    n_cmp++; if (wr_seen !== 1'b0) begin n_fail++; $display("FAIL reset_store_wr_en: got %0b required 0", wr_seen); end
    predict(0, 32'd100, 2'b00, 0, 32'h0, ef, ec, erd, elat);
    do_req(0, 32'd100, 2'b00, 0, 32'h0, lat, rd, f, c, wp, wa);
    $display("reset_store: wr_en=%0b readback=%h", wr_seen, rd);
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL reset_store_commit: got %h required %h", rd, erd); end
  endtask

  task automatic test_saturation();
    bit f, ef; logic [1:0] c, ec; logic [31:0] rd, erd, wa; int lat, elat, wp;
    force dut.stat_faults_q = 16'hFFFF;
    @(negedge clk);
    release dut.stat_faults_q;
    exp_faults = 65535;
    predict(0, 32'd300, 2'b00, 0, 32'h0, ef, ec, erd, elat);
    do_req(0, 32'd300, 2'b00, 0, 32'h0, lat, rd, f, c, wp, wa);
    $display("saturation: fault=%0b stat_faults=%h", f, stat_faults);
    n_cmp++; if (stat_faults !== 16'(exp_faults) || f !== 1'b1) begin n_fail++; $display("FAIL saturation: got %h fault=%0b required %h/1", stat_faults, f, 16'(exp_faults)); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_loads = 0; exp_stores = 0; exp_faults = 0;
    for (int i = 0; i < 256; i++) begin init_img[i] = 8'($urandom); end
    init_img[8] = 8'hEF; init_img[9] = 8'hBE; init_img[10] = 8'hAD; init_img[11] = 8'hDE;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];
    test_reset();
    test_store_byte();
    test_word_load();
    test_iwrite();
    test_priority();
    test_mmio_store();
    test_back_to_back();
    test_random();
    test_reset_wait();
    test_reset_store();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
